bsg_catmap_ctrl: RTL and testbench



---
 rtl/bsg_catmap_pkg.sv | 27 ++
 rtl/bsg_catmap_period.sv | 123 ++++++++++++
 rtl/bsg_catmap_ctrl.sv | 167 ++++++++++++++++
 tb/tb_bsg_catmap_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_catmap_pkg.sv
// Shared types and constants for the Arnold's cat map cipher controller.
package bsg_catmap_pkg;

  // Top-level job states.
  typedef enum logic [1:0] {eIDLE, eCALC, eRUN, eDONE} catmap_state_e;

  // Phases of the period / remainder calculator.
  typedef enum logic [1:0] {eP_IDLE, eP_POW, eP_MOD, eP_FIN} catmap_calc_e;

  // Powers of this base are compared against N to classify the period.
  localparam int unsigned catmap_base_lp   = 5;

  // Period multipliers: 3N, 2N, or floor(12N/7).
  localparam int unsigned catmap_mul_f2_lp = 3;
  localparam int unsigned catmap_mul_f1_lp = 2;
  localparam int unsigned catmap_num_lp    = 12;
  localparam int unsigned catmap_den_lp    = 7;

  // Divisor used for the N/6 power test.
  localparam int unsigned catmap_six_lp    = 6;

  // Width of a counter holding 0..x-1, never narrower than one bit.
  function automatic int catmap_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_catmap_period.sv
// Sequential cat-map period calculator. On start_i it latches N and the frame
// count, walks powers of 5 to classify N, derives the period T, then reduces
// frames mod T by shifted subtraction. done_o pulses for one cycle with
// period_o = T and count_o = T - (frames mod T). A new start_i restarts it.
module bsg_catmap_period
  import bsg_catmap_pkg::*;
#(
  parameter int max_board_width_p = 256,
  parameter int max_game_length_p = 1024,
  localparam int width_w_lp = catmap_clog2(max_board_width_p + 1),
  localparam int len_w_lp   = catmap_clog2(max_game_length_p + 1),
  localparam int iter_w_lp  = catmap_clog2(3 * max_board_width_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [width_w_lp-1:0] width_i,
  input  logic [len_w_lp-1:0]   frames_i,
  output logic                  done_o,
  output logic [iter_w_lp-1:0]  period_o,
  output logic [iter_w_lp-1:0]  count_o
);

  // p can reach 5x the largest power not above N, so 3 extra bits suffice.
  localparam int p_w_lp    = width_w_lp + 3;
  localparam int wide_lp   = iter_w_lp + len_w_lp + 4;
  localparam int step_w_lp = catmap_clog2(len_w_lp + 1);

  catmap_calc_e          phase_r;
  logic [width_w_lp-1:0] n_r;
  logic [len_w_lp-1:0]   rem_r;
  logic [p_w_lp-1:0]     p_r;
  logic                  f1_r, f2_r, f6_r;
  logic [iter_w_lp-1:0]  period_r;
  logic [wide_lp-1:0]    div_r;
  logic [step_w_lp-1:0]  step_r;

  logic [p_w_lp-1:0]     n_p;
  logic [wide_lp-1:0]    n_wide;
  logic [wide_lp-1:0]    period_calc;
  logic [wide_lp-1:0]    rem_wide;
  logic [iter_w_lp-1:0]  period_next;
  logic                  hit_f1, hit_f2, hit_f6;
  logic                  pow_done;
  logic                  rem_ge;

  // Power-of-5 flag tests, period selection and the subtract compare.
  // NOTE: every always_comb output is assigned on every path, so no latches.
  always_comb begin
    n_p      = p_w_lp'(n_r);
    n_wide   = wide_lp'(n_r);
    hit_f2   = ~n_r[0] && (p_r == (n_p >> 1));
    hit_f1   = (p_r == n_p);
    hit_f6   = ((n_r % width_w_lp'(catmap_six_lp)) == '0)
               && (p_r == (n_p / p_w_lp'(catmap_six_lp)));
    pow_done = (p_r > n_p);
    if (f2_r) begin
      period_calc = n_wide * wide_lp'(catmap_mul_f2_lp);
    end else if (f1_r || f6_r) begin
      period_calc = n_wide * wide_lp'(catmap_mul_f1_lp);
    end else begin
      period_calc = (n_wide * wide_lp'(catmap_num_lp)) / wide_lp'(catmap_den_lp);
    end
    period_next = period_calc[iter_w_lp-1:0];
    rem_wide    = wide_lp'(rem_r);
    rem_ge      = (rem_wide >= div_r);
  end

  // Calculator sequencing: power walk, then one quotient bit per cycle.
  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      phase_r  <= eP_IDLE;
      n_r      <= '0;
      rem_r    <= '0;
      p_r      <= '0;
      f1_r     <= 1'b0;
      f2_r     <= 1'b0;
      f6_r     <= 1'b0;
      period_r <= '0;
      div_r    <= '0;
      step_r   <= '0;
    end else if (start_i) begin
      phase_r <= eP_POW;
      n_r     <= width_i;
      rem_r   <= frames_i;
      p_r     <= p_w_lp'(1);
      f1_r    <= 1'b0;
      f2_r    <= 1'b0;
      f6_r    <= 1'b0;
    end else begin
      case (phase_r)
        eP_POW: begin
          if (pow_done) begin
            // Divisor starts at T << (len-1); remainder ends below T.
            period_r <= period_next;
            div_r    <= wide_lp'(period_next) << (len_w_lp - 1);
            step_r   <= step_w_lp'(len_w_lp);
            phase_r  <= eP_MOD;
          end else begin
            f1_r <= f1_r | hit_f1;
            f2_r <= f2_r | hit_f2;
            f6_r <= f6_r | hit_f6;
            p_r  <= (p_r << 2) + p_r;
          end
        end
        eP_MOD: begin
          if (rem_ge) rem_r <= rem_r - div_r[len_w_lp-1:0];
          div_r  <= div_r >> 1;
          step_r <= step_r - step_w_lp'(1);
          if (step_r == step_w_lp'(1)) phase_r <= eP_FIN;
        end
        eP_FIN:  phase_r <= eP_IDLE;
        default: phase_r <= eP_IDLE;
      endcase
    end
  end

  assign done_o   = (phase_r == eP_FIN);
  assign period_o = period_r;
  assign count_o  = period_r - iter_w_lp'(rem_r);

endmodule

// File: rtl/bsg_catmap_ctrl.sv
// Control FSM for the cat map cipher array. Accepts a job (width, frames,
// mode), strobes the array load, then issues enable cycles: frames for
// encrypt, period - (frames mod period) for decrypt. Reports the number of
// enables issued and an error flag on a valid/yumi result channel.
// Optional build macro BSG_CATMAP_CTRL_PERF_EN adds cycles_o, a saturating
// count of cycles from job accept to result valid.
module bsg_catmap_ctrl
  import bsg_catmap_pkg::*;
#(
  parameter int max_board_width_p = 256,
  parameter int max_game_length_p = 1024,
  localparam int width_w_lp = catmap_clog2(max_board_width_p + 1),
  localparam int len_w_lp   = catmap_clog2(max_game_length_p + 1),
  localparam int iter_w_lp  = catmap_clog2(3 * max_board_width_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [width_w_lp-1:0] width_i,
  input  logic [len_w_lp-1:0]   frames_i,
  input  logic                  decrypt_i,
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic                  abort_i,
  output logic                  v_o,
  input  logic                  yumi_i,
  output logic                  err_o,
  output logic [iter_w_lp-1:0]  iters_o,
  output logic                  update_o,
  output logic                  en_o
`ifdef BSG_CATMAP_CTRL_PERF_EN
  ,
  output logic [31:0]           cycles_o
`endif
);

  // Encrypt counts come from frames_i, decrypt counts from the period.
  localparam int cnt_w_lp = (iter_w_lp > len_w_lp) ? iter_w_lp : len_w_lp;

  catmap_state_e         state_r, state_n;
  logic [cnt_w_lp-1:0]   cnt_r;
  logic [iter_w_lp-1:0]  iters_r;
  logic                  err_r;

  logic                  accept;
  logic                  bad_width;
  logic                  calc_start;
  logic                  last_en;
  logic                  calc_done;
  logic [iter_w_lp-1:0]  calc_period;
  logic [iter_w_lp-1:0]  calc_count;

  assign accept     = (state_r == eIDLE) && v_i;
  assign bad_width  = (width_i == '0) || (width_i == width_w_lp'(1))
                      || (32'(width_i) > 32'(max_board_width_p));
  assign calc_start = accept && !bad_width && decrypt_i;
  assign last_en    = (state_r == eRUN) && (cnt_r == cnt_w_lp'(1));

  bsg_catmap_period #(
    .max_board_width_p(max_board_width_p),
    .max_game_length_p(max_game_length_p)
  ) period_calc (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .start_i  (calc_start),
    .width_i  (width_i),
    .frames_i (frames_i),
    .done_o   (calc_done),
    .period_o (calc_period),
    .count_o  (calc_count)
  );

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= eIDLE;
    else            state_r <= state_n;
  end

  // Next-state logic; in RUN the final enable beats a same-cycle abort.
  always_comb begin
    state_n = state_r;
    case (state_r)
      eIDLE: begin
        if (v_i) begin
          if (bad_width)            state_n = eDONE;
          else if (decrypt_i)       state_n = eCALC;
          else if (frames_i == '0)  state_n = eDONE;
          else                      state_n = eRUN;
        end
      end
      eCALC: begin
        if (abort_i)                state_n = eDONE;
        else if (calc_done)         state_n = (calc_count == '0) ? eDONE : eRUN;
      end
      eRUN: begin
        if (last_en || abort_i)     state_n = eDONE;
      end
      eDONE: begin
        if (yumi_i)                 state_n = eIDLE;
      end
      default:                      state_n = eIDLE;
    endcase
  end

  // Job datapath: enable countdown, issued-enable count and error flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r   <= '0;
      iters_r <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        eIDLE: begin
          if (v_i) begin
            iters_r <= '0;
            err_r   <= bad_width;
            cnt_r   <= bad_width ? '0 : cnt_w_lp'(frames_i);
          end
        end
        eCALC: begin
          if (abort_i)        err_r <= 1'b1;
          else if (calc_done) cnt_r <= cnt_w_lp'(calc_count);
        end
        eRUN: begin
          if (cnt_r != '0) cnt_r <= cnt_r - cnt_w_lp'(1);
          iters_r <= iters_r + iter_w_lp'(1);
          if (abort_i && !last_en) err_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; the load strobe is masked while in reset.
  always_comb begin
    ready_o  = (state_r == eIDLE);
    update_o = (state_r == eIDLE) && v_i && reset_n_i;
    en_o     = (state_r == eRUN);
    v_o      = (state_r == eDONE);
    err_o    = (state_r == eDONE) && err_r;
    iters_o  = iters_r;
  end

  // A finished calculation never asks for more than one period of enables.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && calc_done) begin
      assert (calc_count <= calc_period && calc_period != '0);
    end
  end

`ifdef BSG_CATMAP_CTRL_PERF_EN
  logic [31:0] cycles_r;

  // Cycles from accept to v_o rise; saturates, holds through DONE and IDLE.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cycles_r <= '0;
    end else if (accept) begin
      cycles_r <= 32'd1;
    end else if ((state_r == eCALC || state_r == eRUN) && cycles_r != '1) begin
      cycles_r <= cycles_r + 32'd1;
    end
  end

  assign cycles_o = cycles_r;
`endif

endmodule

// File: tb/tb_bsg_catmap_ctrl.sv
// Self-checking bench for bsg_catmap_ctrl: directed vectors, error paths,
// abort, hold, mid-job reset and randomized jobs against a period model.
module tb_bsg_catmap_ctrl;

  localparam int max_w   = 256;
  localparam int max_len = 1024;
  localparam int width_w = $clog2(max_w + 1);
  localparam int len_w   = $clog2(max_len + 1);
  localparam int iter_w  = $clog2(3 * max_w + 1);
  localparam int budget  = 4000;

  logic               clk_i = 1'b0;
  logic               reset_n_i = 1'b0;
  logic [width_w-1:0] width_i = '0;
  logic [len_w-1:0]   frames_i = '0;
  logic               decrypt_i = 1'b0;
  logic               v_i = 1'b0;
  logic               ready_o;
  logic               abort_i = 1'b0;
  logic               v_o;
  logic               yumi_i = 1'b0;
  logic               err_o;
  logic [iter_w-1:0]  iters_o;
  logic               update_o;
  logic               en_o;
`ifdef BSG_CATMAP_CTRL_PERF_EN
  logic [31:0]        cycles_o;
`endif

  int checks = 0;
  int errors = 0;

  bsg_catmap_ctrl #(
    .max_board_width_p(max_w),
    .max_game_length_p(max_len)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .width_i  (width_i),
    .frames_i (frames_i),
    .decrypt_i(decrypt_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .abort_i  (abort_i),
    .v_o      (v_o),
    .yumi_i   (yumi_i),
    .err_o    (err_o),
    .iters_o  (iters_o),
    .update_o (update_o),
    .en_o     (en_o)
`ifdef BSG_CATMAP_CTRL_PERF_EN
    ,
    .cycles_o (cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Enables a job should issue, straight from the cat-map period rules.
  function automatic int model_count(input int n, input int frames, input bit dec);
    int t;
    bit f1, f2, f6;
    f1 = 0; f2 = 0; f6 = 0;
    if (!dec) return frames;
    for (int p = 1; p <= n; p = p * 5) begin
      if (n % 2 == 0 && p == n / 2) f2 = 1;
      if (p == n) f1 = 1;
      if (n % 6 == 0 && p == n / 6) f6 = 1;
    end
    if (f2)            t = 3 * n;
    else if (f1 || f6) t = 2 * n;
    else               t = (12 * n) / 7;
    return t - (frames % t);
  endfunction

  // Drive one job, watch it to completion, hold the result, then take it.
  // exp_hint >= 0 overrides the model's enable count.
  task automatic run_job(input string name, input int n, input int frames, input bit dec,
                         input int abort_at, input int hold, input int exp_hint);
    int exp_cnt, exp_iters, en_seen, upd_seen, cyc;
    bit bad, exp_err, done_seen;
    bad = (n == 0) || (n == 1) || (n > max_w);
    exp_cnt = bad ? 0 : ((exp_hint >= 0) ? exp_hint : model_count(n, frames, dec));
    exp_err = bad || (abort_at > 0 && abort_at < exp_cnt);
    exp_iters = (abort_at > 0 && abort_at < exp_cnt) ? abort_at : exp_cnt;

    @(negedge clk_i);
    width_i = width_w'(n); frames_i = len_w'(frames); decrypt_i = dec; v_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1 || update_o !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: ready_o=%b update_o=%b expected 1 1", name, ready_o, update_o);
    end
    @(negedge clk_i);
    v_i = 1'b0;
    width_i = width_w'($urandom); frames_i = len_w'($urandom); decrypt_i = 1'($urandom);
    #1;
    cyc = 1; done_seen = 0; en_seen = 0; upd_seen = 0;
    while (!done_seen && cyc < budget) begin
      abort_i = 1'b0;
      if (v_o === 1'b1) begin
        done_seen = 1;
      end else begin
        if (en_o === 1'b1) begin
          en_seen++;
          if (en_seen == abort_at) abort_i = 1'b1;
        end
        if (update_o === 1'b1) upd_seen++;
        @(negedge clk_i);
        cyc++;
      end
    end
    abort_i = 1'b0;

    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s timeout: v_o not seen in %0d cycles", name, budget);
    end
    checks++;
    if (en_seen != exp_cnt && !(abort_at > 0 && abort_at < exp_cnt)) begin
      errors++;
      $display("FAIL %s en_cycles: got %0d expected %0d", name, en_seen, exp_cnt);
    end
    checks++;
    if (iters_o !== iter_w'(exp_iters) || err_o !== exp_err) begin
      errors++;
      $display("FAIL %s result: iters_o=%0d err_o=%b expected %0d %b",
               name, iters_o, err_o, exp_iters, exp_err);
    end
    checks++;
    if (upd_seen != 0) begin
      errors++;
      $display("FAIL %s update_after_accept: got %0d strobes expected 0", name, upd_seen);
    end
    if (!dec || bad) begin
      checks++;
      if (cyc != exp_iters + 1) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles expected %0d", name, cyc, exp_iters + 1);
      end
    end

    for (int i = 0; i < hold; i++) begin
      v_i = 1'b1; width_i = width_w'($urandom_range(2, 200)); frames_i = len_w'($urandom);
      @(negedge clk_i);
      #1;
      checks++;
      if (v_o !== 1'b1 || ready_o !== 1'b0 || en_o !== 1'b0
          || iters_o !== iter_w'(exp_iters) || err_o !== exp_err) begin
        errors++;
        $display("FAIL %s hold[%0d]: v_o=%b ready_o=%b en_o=%b iters_o=%0d err_o=%b expected 1 0 0 %0d %b",
                 name, i, v_o, ready_o, en_o, iters_o, err_o, exp_iters, exp_err);
      end
    end

    v_i = 1'b0; yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
    #1;
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s release: v_o=%b ready_o=%b expected 0 1", name, v_o, ready_o);
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; v_i = 1'b1; width_i = width_w'(10); decrypt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || en_o !== 1'b0 || update_o !== 1'b0
        || err_o !== 1'b0 || iters_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b v=%b en=%b upd=%b err=%b iters=%0d expected 1 0 0 0 0 0",
               ready_o, v_o, en_o, update_o, err_o, iters_o);
    end
    v_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b v=%b en=%b expected 1 0 0", ready_o, v_o, en_o);
    end
  endtask

  task automatic test_decrypt_vectors();
    run_job("dec_n10_f7",  10, 7,  1'b1, 0, 0, 23);
    run_job("dec_n25_f60", 25, 60, 1'b1, 0, 0, 40);
    run_job("dec_n30_f0",  30, 0,  1'b1, 0, 0, 60);
    run_job("dec_n64_f9",  64, 9,  1'b1, 0, 0, 100);
  endtask

  task automatic test_encrypt();
    run_job("enc_n64_f5", 64, 5, 1'b0, 0, 0, 5);
    run_job("enc_n64_f0", 64, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_bad_width();
    run_job("bad_w0",   0,   12, 1'b1, 0, 0, 0);
    run_job("bad_w300", 300, 12, 1'b0, 0, 0, 0);
    run_job("bad_w1",   1,   12, 1'b1, 0, 0, 0);
  endtask

  task automatic test_abort();
    run_job("abort_run4",  64, 20, 1'b0, 4,  0, 20);
    run_job("abort_dec10", 10, 7,  1'b1, 10, 0, 23);
    run_job("abort_last",  64, 6,  1'b0, 6,  0, 6);
    // Abort during the first CALC cycle.
    @(negedge clk_i);
    width_i = width_w'(64); frames_i = len_w'(9); decrypt_i = 1'b1; v_i = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
    #1;
    checks++;
    if (en_o !== 1'b0 || v_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_calc_state: en=%b v=%b ready=%b expected 0 0 0", en_o, v_o, ready_o);
    end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    checks++;
    if (v_o !== 1'b1 || err_o !== 1'b1 || iters_o !== '0) begin
      errors++;
      $display("FAIL abort_calc_result: v=%b err=%b iters=%0d expected 1 1 0", v_o, err_o, iters_o);
    end
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
  endtask

  task automatic test_hold();
    run_job("hold20", 25, 60, 1'b1, 0, 20, 40);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk_i);
    width_i = width_w'(64); frames_i = len_w'(50); decrypt_i = 1'b0; v_i = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
    repeat (9) @(negedge clk_i);
    checks++;
    if (en_o !== 1'b1) begin
      errors++;
      $display("FAIL midrun_en: en_o=%b expected 1", en_o);
    end
    reset_n_i = 1'b0; v_i = 1'b1;
    #1;
    checks++;
    if (en_o !== 1'b0 || ready_o !== 1'b1 || v_o !== 1'b0 || update_o !== 1'b0 || iters_o !== '0) begin
      errors++;
      $display("FAIL midrun_reset: en=%b ready=%b v=%b upd=%b iters=%0d expected 0 1 0 0 0",
               en_o, ready_o, v_o, update_o, iters_o);
    end
    @(negedge clk_i);
    v_i = 1'b0; reset_n_i = 1'b1;
    @(negedge clk_i);
    run_job("post_reset", 10, 7, 1'b1, 0, 0, 23);
  endtask

  task automatic test_random();
    int n, frames, abort_at, hold;
    bit dec;
    for (int j = 0; j < 25; j++) begin
      if ($urandom_range(0, 9) < 8) n = $urandom_range(2, max_w);
      else                          n = $urandom_range(0, 300);
      frames   = $urandom_range(0, max_len - 1);
      dec      = 1'($urandom);
      abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 60) : 0;
      hold     = $urandom_range(0, 3);
      run_job($sformatf("rand%0d_n%0d_f%0d_d%0d", j, n, frames, dec), n, frames, dec,
              abort_at, hold, -1);
    end
  endtask

  initial begin
    test_reset();
    test_decrypt_vectors();
    test_encrypt();
    test_bad_width();
    test_abort();
    test_hold();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
